axi_sram_slave: RTL and testbench

//  AXI4 responder (slave end) converting single-ID AXI bursts into a 1-port synchronous SRAM.

---
 rtl/axi_sram_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave that serves single-ID bursts from a 1-port synchronous SRAM.
// It handles one transaction at a time. AW and AR are arbitrated round-robin.
// Reads take two cycles per beat (request, then data). Writes go to the SRAM in the same
// cycle as the W handshake.
module axi_sram_slave #(
    parameter int ID_W    = 8,
    parameter int SRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    // write address channel
    input  logic [ID_W-1:0]    awid,
    input  logic [31:0]        awaddr,
    input  logic [3:0]         awlen,
    input  logic [2:0]         awsize,
    input  logic [1:0]         awburst,
    input  logic               awvalid,
    output logic               awready,
    // write data channel
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    // write response channel
    output logic [ID_W-1:0]    bid,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    // read address channel
    input  logic [ID_W-1:0]    arid,
    input  logic [31:0]        araddr,
    input  logic [3:0]         arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    input  logic               arvalid,
    output logic               arready,
    // read data channel
    output logic [ID_W-1:0]    rid,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic               rvalid,
    input  logic               rready,
    // SRAM port
    output logic               sram_cs,
    output logic               sram_oe,
    output logic [3:0]         sram_web,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [31:0]        sram_di,
    input  logic [31:0]        sram_do
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;

    localparam logic PRIO_WRITE = 1'b0;
    localparam logic PRIO_READ  = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic               prio_q;
    logic [ID_W-1:0]    id_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [SRAM_AW-1:0] addr_next;
    logic [3:0]         len_q;
    logic [3:0]         cnt_q;
    logic               fixed_q;
    logic               err_q;

    // sram_do is valid during the cycle after RD_REQ. rd_vld_p1 marks that cycle, and
    // rdata_p1 keeps the word so the R beat stays stable under backpressure.
    logic               rd_vld_p1;
    logic [31:0]        rdata_p1;

    logic aw_fire;
    logic ar_fire;
    logic w_fire;
    logic r_fire;
    logic b_fire;
    logic last_beat;

    // Size and sub-word/high address bits have no effect on a 32-bit word SRAM.
    logic unused_bits;
    assign unused_bits = ^{awsize, arsize,
                           awaddr[31:SRAM_AW+2], awaddr[1:0],
                           araddr[31:SRAM_AW+2], araddr[1:0]};

    assign last_beat = (cnt_q == len_q);

    // FIXED bursts revisit the same word. INCR wraps within the SRAM word space.
    assign addr_next = fixed_q ? addr_q : addr_q + SRAM_AW'(1);

    // Address-channel readiness in IDLE. When both AW and AR are valid, only the
    // channel that holds priority is offered ready.
    always_comb begin
        awready = 1'b0;
        arready = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            awready = ~(arvalid & (prio_q == PRIO_READ));
            arready = ~(awvalid & (prio_q == PRIO_WRITE));
        end
    end

    assign aw_fire = awvalid & awready;
    assign ar_fire = arvalid & arready;
    assign wready  = (state_q == S_WR);
    assign w_fire  = wvalid & wready;
    assign rvalid  = (state_q == S_RD_DATA);
    assign r_fire  = rvalid & rready;
    assign bvalid  = (state_q == S_WB);
    assign b_fire  = bvalid & bready;

    // Next-state logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (aw_fire) begin
                    state_d = S_WR;
                end else if (ar_fire) begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ:  state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (r_fire) begin
                    state_d = last_beat ? S_IDLE : S_RD_REQ;
                end
            end
            S_WR: begin
                if (w_fire && last_beat) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (b_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, arbitration priority and the latched burst context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= PRIO_WRITE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_fire || ar_fire) begin
                prio_q <= ~prio_q;
            end
            if (aw_fire) begin
                id_q    <= awid;
                addr_q  <= awaddr[SRAM_AW+1:2];
                len_q   <= awlen;
                fixed_q <= (awburst == 2'b00);
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end else if (ar_fire) begin
                id_q    <= arid;
                addr_q  <= araddr[SRAM_AW+1:2];
                len_q   <= arlen;
                fixed_q <= (arburst == 2'b00);
                cnt_q   <= '0;
            end
            // A wlast that disagrees with the beat count is flagged. It does not end the burst.
            if (w_fire) begin
                err_q <= err_q | (wlast != last_beat);
                if (!last_beat) begin
                    cnt_q  <= cnt_q + 4'd1;
                    addr_q <= addr_next;
                end
            end
            if (r_fire && !last_beat) begin
                cnt_q  <= cnt_q + 4'd1;
                addr_q <= addr_next;
            end
        end
    end

    // Read-data stage: mark the cycle where sram_do is valid and capture it for holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
            rdata_p1  <= '0;
        end else begin
            rd_vld_p1 <= (state_q == S_RD_REQ);
            if (rd_vld_p1) begin
                rdata_p1 <= sram_do;
            end
        end
    end

    assign rdata = rd_vld_p1 ? sram_do : rdata_p1;
    assign rid   = id_q;
    assign rresp = RESP_OKAY;
    assign rlast = (state_q == S_RD_DATA) & last_beat;
    assign bid   = id_q;
    assign bresp = (state_q == S_WB && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign sram_cs  = (state_q == S_RD_REQ) | w_fire;
    assign sram_oe  = (state_q == S_RD_REQ);
    assign sram_web = w_fire ? wstrb : 4'b0000;
    assign sram_a   = addr_q;
    assign sram_di  = w_fire ? wdata : 32'h0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: scoreboard bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;

    logic        clk;
    logic        rst;
    logic [7:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata, sram_di, sram_do;
    logic [3:0]  awlen, arlen, wstrb, sram_web;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready, sram_cs, sram_oe;
    logic [13:0] sram_a;

    logic [31:0] mem [0:16383];
    logic        pl_en;
    logic [13:0] pl_a;
    logic [31:0] pl_d;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [7:0] id; logic [31:0] data; logic last; } r_exp_t;
    typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [13:0] a; logic [3:0] web; logic [31:0] di; } w_exp_t;
    r_exp_t rq[$];
    b_exp_t bq[$];
    w_exp_t wq[$];

    axi_sram_slave #(.ID_W(8), .SRAM_AW(14)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
        .sram_di(sram_di), .sram_do(sram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM model: read data appears the cycle after cs&oe, byte-masked writes
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (sram_cs) begin
            if (sram_oe) sram_do <= mem[sram_a];
            for (int b = 0; b < 4; b++)
                if (sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        pl_a = a; pl_d = d; pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, output bit ok);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1; ok = awready;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, output bit ok);
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1; ok = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok,
                          output logic cs, output logic [3:0] web, output logic [13:0] a,
                          output logic [31:0] di);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        ok = 1'b0; cs = 1'b0; web = 4'h0; a = '0; di = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (wready) begin
                ok = 1'b1; cs = sram_cs; web = sram_web; a = sram_a; di = sram_di;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
    endtask

    task automatic get_r(output bit ok, output logic [31:0] d, output logic [7:0] id,
                         output logic l, output logic [1:0] rs, output int waited);
        rready = 1'b1; ok = 1'b0; waited = 0; d = '0; id = '0; l = 1'b0; rs = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (rvalid) begin
                ok = 1'b1; d = rdata; id = rid; l = rlast; rs = rresp;
            end
            @(posedge clk); #1;
            if (!ok) waited++;
        end
        rready = 1'b0;
    endtask

    task automatic get_b(output bit ok, output logic [7:0] id, output logic [1:0] rs);
        bready = 1'b1; ok = 1'b0; id = '0; rs = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (bvalid) begin
                ok = 1'b1; id = bid; rs = bresp;
            end
            @(posedge clk); #1;
        end
        bready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        #1;
        n_tests++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_handshake: got %b, expected 00000",
                               {awready, arready, wready, bvalid, rvalid});
        end
        n_tests++;
        if ({sram_cs, sram_oe, sram_web} !== 6'b0) begin
            n_fail++; $display("FAIL reset_sram: got %b, expected 000000", {sram_cs, sram_oe, sram_web});
        end
        n_tests++;
        if ({bid, rid, bresp, rresp, rlast, rdata} !== 53'b0) begin
            n_fail++; $display("FAIL reset_outputs: got bid=%h rid=%h bresp=%b rresp=%b rlast=%b rdata=%h, expected all zero",
                               bid, rid, bresp, rresp, rlast, rdata);
        end
        rst = 1'b0;
        @(posedge clk); #2;
        n_tests++;
        if ({awready, arready} !== 2'b11) begin
            n_fail++; $display("FAIL idle_ready: got %b, expected 11", {awready, arready});
        end
        tick();
    endtask

    task automatic test_single_write();
        bit ok; logic cs; logic [3:0] web; logic [13:0] a; logic [31:0] di;
        logic [7:0] id; logic [1:0] rs; w_exp_t ew; b_exp_t eb;
        wq.push_back('{a: 14'd4, web: 4'hF, di: 32'hDEADBEEF});
        bq.push_back('{id: 8'd3, resp: 2'b00});
        send_aw(8'd3, 32'h10, 4'd0, 2'b01, ok);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL sw_aw: got no handshake, expected handshake"); end
        send_w(32'hDEADBEEF, 4'hF, 1'b1, ok, cs, web, a, di);
        ew = wq.pop_front();
        n_tests++;
        if ({ok, cs, web, a, di} !== {1'b1, 1'b1, ew.web, ew.a, ew.di}) begin
            n_fail++; $display("FAIL sw_wbeat: got ok=%b cs=%b web=%h a=%h di=%h, expected 1 1 %h %h %h",
                               ok, cs, web, a, di, ew.web, ew.a, ew.di);
        end
        get_b(ok, id, rs);
        eb = bq.pop_front();
        n_tests++;
        if ({ok, id, rs} !== {1'b1, eb.id, eb.resp}) begin
            n_fail++; $display("FAIL sw_bresp: got ok=%b bid=%h bresp=%b, expected 1 %h %b", ok, id, rs, eb.id, eb.resp);
        end
        n_tests++;
        if (mem[4] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sw_mem: got %h, expected deadbeef", mem[4]);
        end
    endtask

    task automatic test_incr_read();
        bit ok; logic [31:0] d; logic [7:0] id; logic l; logic [1:0] rs; int wt; r_exp_t er;
        for (int i = 0; i < 4; i++) begin
            preload(14'(4 + i), 32'hA5A50000 | 32'(i * 17));
            rq.push_back('{id: 8'd5, data: 32'hA5A50000 | 32'(i * 17), last: (i == 3)});
        end
        send_ar(8'd5, 32'h10, 4'd3, 2'b01, ok);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL incr_ar: got no handshake, expected handshake"); end
        for (int i = 0; i < 4; i++) begin
            get_r(ok, d, id, l, rs, wt);
            er = rq.pop_front();
            n_tests++;
            if ({ok, id, d, l, rs} !== {1'b1, er.id, er.data, er.last, 2'b00}) begin
                n_fail++; $display("FAIL incr_beat%0d: got ok=%b rid=%h rdata=%h rlast=%b rresp=%b, expected 1 %h %h %b 00",
                                   i, ok, id, d, l, rs, er.id, er.data, er.last);
            end
            if (i == 0) begin
                n_tests++;
                if (wt !== 1) begin
                    n_fail++; $display("FAIL incr_latency: got %0d idle cycles before rvalid, expected 1", wt);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; bit seen; bit stable; int extra; int wt;
        logic [31:0] d; logic [31:0] d0; logic [7:0] id; logic l; logic l0; logic [1:0] rs; r_exp_t er;
        preload(14'd40, 32'h01234567);
        preload(14'd41, 32'h89ABCDEF);
        rq.push_back('{id: 8'd7, data: 32'h01234567, last: 1'b0});
        rq.push_back('{id: 8'd7, data: 32'h89ABCDEF, last: 1'b1});
        send_ar(8'd7, 32'hA0, 4'd1, 2'b01, ok);
        rready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1; seen = rvalid;
            if (!seen) begin @(posedge clk); #1; end
        end
        d0 = rdata; l0 = rlast;
        stable = 1'b1; extra = 0;
        repeat (5) begin
            @(posedge clk); #2;
            if (sram_cs && sram_oe) extra++;
            if (rvalid !== 1'b1 || rdata !== d0 || rlast !== l0) stable = 1'b0;
        end
        @(posedge clk); #1;
        er = rq.pop_front();
        n_tests++;
        if ({seen, stable, d0, l0} !== {1'b1, 1'b1, er.data, er.last}) begin
            n_fail++; $display("FAIL bp_stall: got seen=%b stable=%b rdata=%h rlast=%b, expected 1 1 %h %b",
                               seen, stable, d0, l0, er.data, er.last);
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL bp_extra_read: got %0d reads during stall, expected 0", extra);
        end
        get_r(ok, d, id, l, rs, wt);
        n_tests++;
        if ({ok, id, d, l} !== {1'b1, er.id, er.data, er.last}) begin
            n_fail++; $display("FAIL bp_beat0: got ok=%b rid=%h rdata=%h rlast=%b, expected 1 %h %h %b",
                               ok, id, d, l, er.id, er.data, er.last);
        end
        get_r(ok, d, id, l, rs, wt);
        er = rq.pop_front();
        n_tests++;
        if ({ok, id, d, l} !== {1'b1, er.id, er.data, er.last}) begin
            n_fail++; $display("FAIL bp_beat1: got ok=%b rid=%h rdata=%h rlast=%b, expected 1 %h %h %b",
                               ok, id, d, l, er.id, er.data, er.last);
        end
    endtask

    task automatic test_partial_strobe();
        bit ok; int wt; logic cs; logic [3:0] web; logic [13:0] a; logic [31:0] di;
        logic [31:0] d; logic [7:0] id; logic l; logic [1:0] rs; w_exp_t ew; r_exp_t er;
        preload(14'd20, 32'hFFFFFFFF);
        wq.push_back('{a: 14'd20, web: 4'b0101, di: 32'h11223344});
        rq.push_back('{id: 8'd10, data: 32'hFF22FF44, last: 1'b1});
        send_aw(8'd9, 32'h50, 4'd0, 2'b01, ok);
        send_w(32'h11223344, 4'b0101, 1'b1, ok, cs, web, a, di);
        ew = wq.pop_front();
        n_tests++;
        if ({ok, cs, web, a} !== {1'b1, 1'b1, ew.web, ew.a}) begin
            n_fail++; $display("FAIL ps_wbeat: got ok=%b cs=%b web=%b a=%h, expected 1 1 %b %h", ok, cs, web, a, ew.web, ew.a);
        end
        get_b(ok, id, rs);
        send_ar(8'd10, 32'h50, 4'd0, 2'b01, ok);
        get_r(ok, d, id, l, rs, wt);
        er = rq.pop_front();
        n_tests++;
        if ({ok, id, d, l} !== {1'b1, er.id, er.data, er.last}) begin
            n_fail++; $display("FAIL ps_readback: got ok=%b rid=%h rdata=%h rlast=%b, expected 1 %h %h %b",
                               ok, id, d, l, er.id, er.data, er.last);
        end
    endtask

    task automatic test_fixed_burst();
        bit ok; int wt; logic cs; logic [3:0] web; logic [13:0] a; logic [31:0] di;
        logic [31:0] d; logic [7:0] id; logic l; logic [1:0] rs; w_exp_t ew; r_exp_t er;
        wq.push_back('{a: 14'd24, web: 4'hF, di: 32'h00000001});
        wq.push_back('{a: 14'd24, web: 4'hF, di: 32'h00000002});
        rq.push_back('{id: 8'd15, data: 32'h00000002, last: 1'b0});
        rq.push_back('{id: 8'd15, data: 32'h00000002, last: 1'b1});
        send_aw(8'd13, 32'h60, 4'd1, 2'b00, ok);
        for (int i = 0; i < 2; i++) begin
            send_w(32'(i + 1), 4'hF, (i == 1), ok, cs, web, a, di);
            ew = wq.pop_front();
            n_tests++;
            if ({ok, cs, a, di} !== {1'b1, 1'b1, ew.a, ew.di}) begin
                n_fail++; $display("FAIL fixed_wbeat%0d: got ok=%b cs=%b a=%h di=%h, expected 1 1 %h %h",
                                   i, ok, cs, a, di, ew.a, ew.di);
            end
        end
        get_b(ok, id, rs);
        send_ar(8'd15, 32'h60, 4'd1, 2'b00, ok);
        for (int i = 0; i < 2; i++) begin
            get_r(ok, d, id, l, rs, wt);
            er = rq.pop_front();
            n_tests++;
            if ({ok, id, d, l} !== {1'b1, er.id, er.data, er.last}) begin
                n_fail++; $display("FAIL fixed_rbeat%0d: got ok=%b rid=%h rdata=%h rlast=%b, expected 1 %h %h %b",
                                   i, ok, id, d, l, er.id, er.data, er.last);
            end
        end
    endtask

    task automatic test_early_wlast();
        bit ok; logic cs; logic [3:0] web; logic [13:0] a; logic [31:0] di;
        logic [7:0] id; logic [1:0] rs; w_exp_t ew; b_exp_t eb;
        for (int i = 0; i < 3; i++) wq.push_back('{a: 14'(16 + i), web: 4'hF, di: 32'hC0DE0000 | 32'(i)});
        bq.push_back('{id: 8'd12, resp: 2'b10});
        send_aw(8'd12, 32'h40, 4'd2, 2'b01, ok);
        for (int i = 0; i < 3; i++) begin
            send_w(32'hC0DE0000 | 32'(i), 4'hF, (i != 0), ok, cs, web, a, di);
            ew = wq.pop_front();
            n_tests++;
            if ({ok, cs, a, di} !== {1'b1, 1'b1, ew.a, ew.di}) begin
                n_fail++; $display("FAIL early_wbeat%0d: got ok=%b cs=%b a=%h di=%h, expected 1 1 %h %h",
                                   i, ok, cs, a, di, ew.a, ew.di);
            end
        end
        get_b(ok, id, rs);
        eb = bq.pop_front();
        n_tests++;
        if ({ok, id, rs} !== {1'b1, eb.id, eb.resp}) begin
            n_fail++; $display("FAIL early_bresp: got ok=%b bid=%h bresp=%b, expected 1 %h %b", ok, id, rs, eb.id, eb.resp);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        for (int i = 0; i < 4; i++) preload(14'(48 + i), 32'h5A5A0000 | 32'(i));
        send_ar(8'd14, 32'hC0, 4'd3, 2'b01, ok);
        rready = 1'b0;
        tick();
        #1;
        n_tests++;
        if (rvalid !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got rvalid=%b, expected 1", rvalid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({rvalid, rlast, sram_cs, rdata, rid} !== 43'b0) begin
            n_fail++; $display("FAIL rst_mid: got rvalid=%b rlast=%b cs=%b rdata=%h rid=%h, expected all zero",
                               rvalid, rlast, sram_cs, rdata, rid);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({awready, arready, wready, bvalid} !== 4'b1100) begin
            n_fail++; $display("FAIL rst_idle: got %b, expected 1100", {awready, arready, wready, bvalid});
        end
        tick();
    endtask

    task automatic test_arbitration();
        bit ok; int wt; logic cs; logic [3:0] web; logic [13:0] a; logic [31:0] di;
        logic [31:0] d; logic [7:0] id; logic l; logic [1:0] rs; logic [1:0] rdy;
        preload(14'd128, 32'h0BADF00D);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        awid = 8'd1; awaddr = 32'h100; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
        arid = 8'd2; araddr = 32'h200; arlen = 4'd0; arburst = 2'b01; arvalid = 1'b1;
        #1; rdy = {awready, arready};
        n_tests++;
        if (rdy !== 2'b10) begin
            n_fail++; $display("FAIL arb_first: got aw/ar ready %b, expected 10", rdy);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        send_w(32'h0000AAAA, 4'hF, 1'b1, ok, cs, web, a, di);
        get_b(ok, id, rs);
        n_tests++;
        if ({ok, id} !== {1'b1, 8'd1}) begin
            n_fail++; $display("FAIL arb_bid1: got ok=%b bid=%h, expected 1 01", ok, id);
        end
        awid = 8'd4; awaddr = 32'h104; awvalid = 1'b1;
        arid = 8'd6; araddr = 32'h200; arvalid = 1'b1;
        #1; rdy = {awready, arready};
        n_tests++;
        if (rdy !== 2'b01) begin
            n_fail++; $display("FAIL arb_second: got aw/ar ready %b, expected 01", rdy);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        get_r(ok, d, id, l, rs, wt);
        n_tests++;
        if ({ok, id, d, l} !== {1'b1, 8'd6, 32'h0BADF00D, 1'b1}) begin
            n_fail++; $display("FAIL arb_read: got ok=%b rid=%h rdata=%h rlast=%b, expected 1 06 0badf00d 1", ok, id, d, l);
        end
        send_aw(8'd4, 32'h104, 4'd0, 2'b01, ok);
        send_w(32'h0000BBBB, 4'hF, 1'b1, ok, cs, web, a, di);
        get_b(ok, id, rs);
        n_tests++;
        if ({ok, id, rs} !== {1'b1, 8'd4, 2'b00}) begin
            n_fail++; $display("FAIL arb_bid4: got ok=%b bid=%h bresp=%b, expected 1 04 00", ok, id, rs);
        end
    endtask

    initial begin
        rst = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_single_write();
        test_incr_read();
        test_backpressure();
        test_partial_strobe();
        test_fixed_burst();
        test_early_wlast();
        test_reset_mid_burst();
        test_arbitration();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
